// File: rtl/store_pkg.sv
// Shared encodings for the store path: access sizes and byte-enable patterns.
package store_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [3:0] BE_ALL = 4'b1111;
  localparam logic [3:0] BE_LO  = 4'b0011;
  localparam logic [3:0] BE_HI  = 4'b1100;

endpackage

// File: rtl/store_align.sv
// Combinational store formatter: replicates register data into every lane,
// builds byte enables and flags misaligned or reserved-size accesses.
module store_align
  import store_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        illegal
);

  always_comb begin
    wdata   = data;
    be      = BE_ALL;
    illegal = 1'b0;
    case (size)
      SZ_WORD: begin
        illegal = (addr_lo != 2'b00);
      end
      SZ_HALF: begin
        wdata   = {2{data[15:0]}};
        be      = addr_lo[1] ? BE_HI : BE_LO;
        illegal = addr_lo[0];
      end
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      default: begin
        be      = 4'b0000;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store path: formats stores at accept, queues legal ones in a small FIFO and
// issues them in order to data memory; illegal stores raise a one-cycle pulse.
module store_unit
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              misalign,
  output logic [ADDR_W-1:0] misalign_addr,
  output logic              busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-3:0] buf_addr_q  [DEPTH];
  logic [ADDR_W-3:0] buf_addr_d  [DEPTH];
  logic [31:0]       buf_wdata_q [DEPTH];
  logic [31:0]       buf_wdata_d [DEPTH];
  logic [3:0]        buf_be_q    [DEPTH];
  logic [3:0]        buf_be_d    [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] misalign_addr_q, misalign_addr_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_illegal;
  logic        accept, push, pop;

  store_align u_align (
    .addr_lo (req_addr[1:0]),
    .data    (req_data),
    .size    (req_size),
    .wdata   (al_wdata),
    .be      (al_be),
    .illegal (al_illegal)
  );

  assign req_ready = (count_q < DEPTH_C);
  assign mem_valid = (count_q != '0);
  assign busy      = mem_valid;
  assign accept    = req_valid && req_ready;
  assign push      = accept && !al_illegal;
  assign pop       = mem_valid && mem_ready;

  always_comb begin
    buf_addr_d      = buf_addr_q;
    buf_wdata_d     = buf_wdata_q;
    buf_be_d        = buf_be_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q + CNT_W'(push) - CNT_W'(pop);
    misalign_d      = accept && al_illegal;
    misalign_addr_d = misalign_addr_q;

    if (push) begin
      buf_addr_d[wr_ptr_q]  = req_addr[ADDR_W-1:2];
      buf_wdata_d[wr_ptr_q] = al_wdata;
      buf_be_d[wr_ptr_q]    = al_be;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (accept && al_illegal) begin
      misalign_addr_d = req_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_addr_q      <= '{default: '0};
      buf_wdata_q     <= '{default: '0};
      buf_be_q        <= '{default: '0};
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      buf_addr_q      <= buf_addr_d;
      buf_wdata_q     <= buf_wdata_d;
      buf_be_q        <= buf_be_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Head fields are forced to zero when the queue is empty.
  assign mem_addr      = mem_valid ? {buf_addr_q[rd_ptr_q], 2'b00} : '0;
  assign mem_wdata     = mem_valid ? buf_wdata_q[rd_ptr_q] : '0;
  assign mem_be        = mem_valid ? buf_be_q[rd_ptr_q] : '0;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with hand-computed expectations.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic        busy;

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  store_unit #(.DEPTH(2), .ADDR_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_size      (req_size),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .busy          (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req_valid = v;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    check_val({tag, "_valid"}, mem_valid, 1'b1);
    check_val({tag, "_addr"}, mem_addr, a);
    check_val({tag, "_wdata"}, mem_wdata, d);
    check_val({tag, "_be"}, mem_be, be);
  endtask

  task automatic check_empty(input string tag);
    check_val({tag, "_valid"}, mem_valid, 1'b0);
    check_val({tag, "_addr"}, mem_addr, 32'h0);
    check_val({tag, "_wdata"}, mem_wdata, 32'h0);
    check_val({tag, "_be"}, mem_be, 4'h0);
    check_val({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    step();
    check_empty("rst");
    check_val("rst_ready", req_ready, 1'b1);
    check_val("rst_mis", misalign, 1'b0);
    check_val("rst_mis_addr", misalign_addr, 32'h0);
    reset_n = 1'b1;
    step();

    // byte store, lane 3
    mem_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_1003, 32'hAABB_CC5A);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_head("sb", 32'h0000_1000, 32'h5A5A_5A5A, 4'b1000);
    check_val("sb_busy", busy, 1'b1);
    step();
    check_empty("sb_done");

    // half then word, overlapped push/pop
    drive(1'b1, 2'b01, 32'h0000_2002, 32'h1234_5678);
    step();
    drive(1'b1, 2'b00, 32'h0000_2004, 32'hDEAD_BEEF);
    check_head("sh", 32'h0000_2000, 32'h5678_5678, 4'b1100);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_head("sw", 32'h0000_2004, 32'hDEAD_BEEF, 4'b1111);
    step();
    check_empty("sw_done");

    // illegal stores
    drive(1'b1, 2'b00, 32'h0000_3001, 32'h0);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_val("mis1", misalign, 1'b1);
    check_val("mis1_addr", misalign_addr, 32'h0000_3001);
    check_val("mis1_novalid", mem_valid, 1'b0);
    step();
    check_val("mis1_end", misalign, 1'b0);
    check_val("mis1_hold", misalign_addr, 32'h0000_3001);
    drive(1'b1, 2'b01, 32'h0000_3005, 32'h0);
    step();
    drive(1'b1, 2'b11, 32'h0000_4000, 32'h0);
    check_val("mis2", misalign, 1'b1);
    check_val("mis2_addr", misalign_addr, 32'h0000_3005);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_val("mis3", misalign, 1'b1);
    check_val("mis3_addr", misalign_addr, 32'h0000_4000);
    step();
    check_val("mis3_end", misalign, 1'b0);
    check_empty("mis_none");

    // backpressure: two accepted, third held
    mem_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_5000, 32'h1111_1111);
    step();
    drive(1'b1, 2'b01, 32'h0000_5006, 32'h0000_ABCD);
    check_val("bp_ready1", req_ready, 1'b1);
    step();
    drive(1'b1, 2'b10, 32'h0000_5009, 32'h0000_00EE);
    check_val("bp_full", req_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_head("bp_stable", 32'h0000_5000, 32'h1111_1111, 4'b1111);
      check_val("bp_stall_ready", req_ready, 1'b0);
      step();
    end
    mem_ready = 1'b1;
    check_head("bp_a", 32'h0000_5000, 32'h1111_1111, 4'b1111);
    step();
    check_head("bp_b", 32'h0000_5004, 32'hABCD_ABCD, 4'b1100);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_head("bp_c", 32'h0000_5008, 32'hEEEE_EEEE, 4'b0010);
    step();
    check_empty("bp_done");

    // streaming: one entry resident, push and pop every cycle
    drive(1'b1, 2'b00, 32'h0000_6000, 32'h0000_0100);
    step();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 2'b00, 32'h0000_6000 + 32'(4 * k), 32'h0000_0100 + 32'(k));
      check_head("stream", 32'h0000_6000 + 32'(4 * (k - 1)), 32'h0000_0100 + 32'(k - 1), 4'b1111);
      check_val("stream_ready", req_ready, 1'b1);
      step();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_head("stream_last", 32'h0000_6018, 32'h0000_0106, 4'b1111);
    step();
    check_empty("stream_done");

    // async reset with two queued entries
    mem_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_7000, 32'h7777_7777);
    step();
    drive(1'b1, 2'b00, 32'h0000_7004, 32'h8888_8888);
    step();
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    check_val("pre_rst_busy", busy, 1'b1);
    check_val("pre_rst_ready", req_ready, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_empty("async_rst");
    #1;
    reset_n = 1'b1;
    step();
    check_val("post_rst_ready", req_ready, 1'b1);
    check_val("post_rst_valid", mem_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
